// File: rtl/volume_pkg.sv
// Shared types and constants for the mic volume history block.
package volume_pkg;
  localparam int LEVEL_W     = 4;
  localparam int HIST_DEPTH  = 16;
  localparam int SAMPLE_W    = 12;
  localparam int MIC_MID     = 2048;
  localparam int QUANT_SHIFT = 7;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_QUANT = 2'd1,
    S_PUSH  = 2'd2
  } state_t;

  // Peak amplitude to bar height; amplitudes above the top bar saturate.
  function automatic level_t quantise(input logic [SAMPLE_W-1:0] amp);
    logic [SAMPLE_W-1:0] s;
    s = amp >> QUANT_SHIFT;
    if (s > SAMPLE_W'((1 << LEVEL_W) - 1)) return level_t'((1 << LEVEL_W) - 1);
    return s[LEVEL_W-1:0];
  endfunction
endpackage

// File: rtl/mic_peak_window.sv
// Per-window peak amplitude tracker: |sample - midpoint| max over WINDOW valid samples,
// with a terminal-sample strobe and the closing peak held in r_peak_q.
module mic_peak_window
  import volume_pkg::*;
#(
  parameter int WINDOW  = 4000,
  parameter int MIC_MID_P = MIC_MID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_sample_valid,
  input  logic [SAMPLE_W-1:0] i_mic_sample,
  output logic                o_term,
  output logic [SAMPLE_W-1:0] o_peak_q
);
  localparam int CNT_W = $clog2(WINDOW);

  logic [SAMPLE_W-1:0] w_mid;
  logic [SAMPLE_W-1:0] w_amp;
  logic [SAMPLE_W-1:0] w_peak_next;
  logic [SAMPLE_W-1:0] r_peak;
  logic [SAMPLE_W-1:0] r_peak_q;
  logic [CNT_W-1:0]    r_win_cnt;
  logic                w_term;

  assign w_mid       = SAMPLE_W'(MIC_MID_P);
  assign w_amp       = (i_mic_sample >= w_mid) ? (i_mic_sample - w_mid) : (w_mid - i_mic_sample);
  assign w_peak_next = (w_amp > r_peak) ? w_amp : r_peak;
  assign w_term      = i_sample_valid && (r_win_cnt == CNT_W'(WINDOW - 1));

  // The terminal sample belongs to the closing window, so peak_q takes w_peak_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_peak    <= '0;
      r_peak_q  <= '0;
      r_win_cnt <= '0;
    end else if (i_sample_valid) begin
      if (w_term) begin
        r_peak_q  <= w_peak_next;
        r_peak    <= '0;
        r_win_cnt <= '0;
      end else begin
        r_peak    <= w_peak_next;
        r_win_cnt <= r_win_cnt + CNT_W'(1);
      end
    end
  end

  assign o_term   = w_term;
  assign o_peak_q = r_peak_q;
endmodule

// File: rtl/mic_volume_history.sv
// Mic loudness levels with a 16-deep scrolling history and registered column read port.
// Optional decaying peak-hold marker when PEAK_HOLD_EN is defined.
module mic_volume_history
  import volume_pkg::*;
#(
  parameter int WINDOW    = 4000,
  parameter int MIC_MID_P = MIC_MID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] mic_sample,
  input  logic                freeze,
  input  logic [3:0]          col_idx,
  output logic [LEVEL_W-1:0]  col_level,
  output logic [LEVEL_W-1:0]  cur_level,
  output logic                level_valid,
  output logic [LEVEL_W-1:0]  hold_level
);
  // state   | meaning
  // S_ACCUM | collecting samples, waiting for the terminal sample
  // S_QUANT | quantise the closed window's peak into cur_level
  // S_PUSH  | pulse level_valid and scroll history unless frozen

  generate
    if (WINDOW < 3) begin : g_window_check
      $error("mic_volume_history: WINDOW must be >= 3");
    end
  endgenerate

  logic                w_term;
  logic [SAMPLE_W-1:0] w_peak_q;
  state_t              r_state;
  level_t              r_cur_level;
  logic                r_level_valid;
  level_t              r_col_level;
  level_t              r_hist [HIST_DEPTH];

  mic_peak_window #(
    .WINDOW    (WINDOW),
    .MIC_MID_P (MIC_MID_P)
  ) u_peak (
    .clk            (clk),
    .rst            (rst),
    .i_sample_valid (sample_valid),
    .i_mic_sample   (mic_sample),
    .o_term         (w_term),
    .o_peak_q       (w_peak_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_ACCUM;
      r_cur_level   <= '0;
      r_level_valid <= 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else begin
      r_level_valid <= 1'b0;
      case (r_state)
        S_ACCUM: if (w_term) r_state <= S_QUANT;
        S_QUANT: begin
          r_cur_level <= quantise(w_peak_q);
          r_state     <= S_PUSH;
        end
        S_PUSH: begin
          r_level_valid <= 1'b1;
          if (!freeze) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
            r_hist[0] <= r_cur_level;
          end
          r_state <= S_ACCUM;
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  // Reads coinciding with a shift see the pre-shift contents.
  always_ff @(posedge clk) begin
    if (rst) r_col_level <= '0;
    else     r_col_level <= r_hist[col_idx];
  end

`ifdef PEAK_HOLD_EN
  level_t r_hold;

  // Decays by one per committed window; updated even while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_state == S_PUSH) begin
      r_hold <= (r_cur_level >= r_hold) ? r_cur_level : r_hold - level_t'(1);
    end
  end

  assign hold_level = r_hold;
`else
  assign hold_level = '0;
`endif

  assign col_level   = r_col_level;
  assign cur_level   = r_cur_level;
  assign level_valid = r_level_valid;
endmodule
